alien_sprite_renderer: RTL and testbench

- Consumes the (x, y) position stream produced by an alien movement controller and converts it into pixel writes for the 160x120 VGA framebuffer adapter.
- On every position change, it first erases the sprite at the previously drawn position with the background colour, then draws the sprite bitmap at the new position.
- It sits between the alien game logic and the VGA adapter's plot/x/y/colour write port.

---
 rtl/alien_sprite_renderer.sv | 135 +++++++++++++
 tb/tb_alien_sprite_renderer.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alien_sprite_renderer.sv
// Turns alien position updates into framebuffer pixel writes: erase the old sprite, then draw the new one.
// One pixel per cycle while busy; position changes during a render are dropped in favour of the latest one.
module alien_sprite_renderer #(
  parameter int                     SPR_W        = 8,
  parameter int                     SPR_H        = 4,
  parameter logic [SPR_W*SPR_H-1:0] SPRITE       = 32'hA5FFDB3C,
  parameter logic [2:0]             ALIEN_COLOUR = 3'b010,
  parameter logic [2:0]             BG_COLOUR    = 3'b000,
  parameter int                     SCR_W        = 160,
  parameter int                     SCR_H        = 120
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] alien_x,
  input  logic [6:0] alien_y,
  input  logic       redraw,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       done
);

  localparam int CW = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int RW = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int IW = (SPR_W * SPR_H > 1) ? $clog2(SPR_W * SPR_H) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(SPR_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(SPR_H - 1);

  typedef enum logic [1:0] {IDLE, ERASE, DRAW, FINISH} state_t;

  state_t        state, state_n;
  logic [CW-1:0] col, col_n;
  logic [RW-1:0] row, row_n;
  logic [7:0]    new_x, drawn_x, base_x, pix_x;
  logic [6:0]    new_y, drawn_y, base_y, pix_y;
  logic [IW-1:0] pix_idx;
  logic          drawn_valid;
  logic          trigger, last_pix, scanning_n, clipped, opaque;

  // Output registers are loaded from the next state/counters so a pixel appears in the same cycle as its state.
  always_comb begin
    state_n  = state;
    col_n    = col;
    row_n    = row;
    trigger  = (alien_x != drawn_x) || (alien_y != drawn_y) || !drawn_valid || redraw;
    last_pix = (col == COL_LAST) && (row == ROW_LAST);

    case (state)
      IDLE: begin
        if (trigger) begin
          state_n = drawn_valid ? ERASE : DRAW;
          col_n   = '0;
          row_n   = '0;
        end
      end
      ERASE, DRAW: begin
        if (last_pix) begin
          state_n = (state == ERASE) ? DRAW : FINISH;
          col_n   = '0;
          row_n   = '0;
        end else if (col == COL_LAST) begin
          col_n = '0;
          row_n = row + 1'b1;
        end else begin
          col_n = col + 1'b1;
        end
      end
      FINISH:  state_n = IDLE;
      default: state_n = IDLE;
    endcase

    scanning_n = (state_n == ERASE) || (state_n == DRAW);

    // A draw starting straight from IDLE has not latched new_x/new_y yet, so take the live inputs.
    if (state_n == ERASE) begin
      base_x = drawn_x;
      base_y = drawn_y;
    end else if (state == IDLE) begin
      base_x = alien_x;
      base_y = alien_y;
    end else begin
      base_x = new_x;
      base_y = new_y;
    end

    pix_x   = base_x + 8'(col_n);
    pix_y   = base_y + 7'(row_n);
    pix_idx = IW'(row_n) * IW'(SPR_W) + IW'(col_n);
    clipped = (int'(pix_x) >= SCR_W) || (int'(pix_y) >= SCR_H);
    opaque  = (state_n == ERASE) || SPRITE[pix_idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      col         <= '0;
      row         <= '0;
      new_x       <= '0;
      new_y       <= '0;
      drawn_x     <= '0;
      drawn_y     <= '0;
      drawn_valid <= 1'b0;
      vga_x       <= '0;
      vga_y       <= '0;
      colour      <= '0;
      plot        <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state <= state_n;
      col   <= col_n;
      row   <= row_n;
      if (state == IDLE && trigger) begin
        new_x <= alien_x;
        new_y <= alien_y;
      end
      if (state == FINISH) begin
        drawn_x     <= new_x;
        drawn_y     <= new_y;
        drawn_valid <= 1'b1;
      end
      plot <= scanning_n && opaque && !clipped;
      busy <= scanning_n;
      done <= (state_n == FINISH);
      if (scanning_n) begin
        vga_x  <= pix_x;
        vga_y  <= pix_y;
        colour <= (state_n == ERASE) ? BG_COLOUR : ALIEN_COLOUR;
      end
    end
  end

endmodule

// File: tb/tb_alien_sprite_renderer.sv
// Bench for alien_sprite_renderer: expected pixel-write lists are built from the sprite rules and compared per cycle.
module tb_alien_sprite_renderer;

  localparam logic [31:0] MASK = 32'hA5FFDB3C;

  typedef struct packed {
    logic [15:0] cyc;
    logic [7:0]  x;
    logic [6:0]  y;
    logic [2:0]  c;
  } ev_t;

  logic       clk = 1'b0;
  logic       reset, redraw;
  logic [7:0] alien_x;
  logic [6:0] alien_y;
  logic [7:0] vga_x;
  logic [6:0] vga_y;
  logic [2:0] colour;
  logic       plot, busy, done;

  int   checks = 0;
  int   errors = 0;
  ev_t  exp_q[$];
  ev_t  got_q[$];
  int   exp_done, done_k, busy_cnt, stray;
  bit   m_valid;
  logic [7:0] m_x;
  logic [6:0] m_y;

  always #5 clk = ~clk;

  alien_sprite_renderer dut (
    .clk(clk), .reset(reset), .alien_x(alien_x), .alien_y(alien_y), .redraw(redraw),
    .vga_x(vga_x), .vga_y(vga_y), .colour(colour), .plot(plot), .busy(busy), .done(done)
  );

  // Expected writes (with cycle offset from the trigger cycle) for moving the model sprite to (nx,ny).
  task automatic build_expected(input logic [7:0] nx, input logic [6:0] ny);
    int base, x, y;
    exp_q.delete();
    base = 1;
    if (m_valid) begin
      for (int i = 0; i < 32; i++) begin
        x = (int'(m_x) + i % 8) % 256;
        y = (int'(m_y) + i / 8) % 128;
        if (x < 160 && y < 120) exp_q.push_back('{16'(base + i), 8'(x), 7'(y), 3'b000});
      end
      base += 32;
    end
    for (int i = 0; i < 32; i++) begin
      x = (int'(nx) + i % 8) % 256;
      y = (int'(ny) + i / 8) % 128;
      if (MASK[i] && x < 160 && y < 120) exp_q.push_back('{16'(base + i), 8'(x), 7'(y), 3'b010});
    end
    exp_done = base + 32;
    m_valid  = 1'b1;
    m_x      = nx;
    m_y      = ny;
  endtask

  // Records writes from the current negedge (cycle T) until done or the cycle budget runs out.
  task automatic capture(input int limit, input int chg_k1 = -1, input logic [7:0] chg_x1 = 8'd0,
                         input int chg_k2 = -1, input logic [7:0] chg_x2 = 8'd0);
    got_q.delete();
    done_k = -1; busy_cnt = 0; stray = 0;
    for (int k = 0; k <= limit && done_k < 0; k++) begin
      if (k > 0) @(negedge clk);
      if (k == 1) redraw = 1'b0;
      if (k == chg_k1) alien_x = chg_x1;
      if (k == chg_k2) alien_x = chg_x2;
      if (plot) got_q.push_back('{16'(k), vga_x, vga_y, colour});
      if (busy) busy_cnt++;
      if (plot && !busy) stray++;
      if (done) done_k = k;
    end
  endtask

  function automatic int first_diff();
    int n;
    n = (exp_q.size() < got_q.size()) ? exp_q.size() : got_q.size();
    for (int i = 0; i < n; i++) if (exp_q[i] !== got_q[i]) return i;
    return (exp_q.size() == got_q.size()) ? -1 : n;
  endfunction

  function automatic ev_t ev_at(input bit from_exp, input int i);
    if (from_exp) return (i >= 0 && i < exp_q.size()) ? exp_q[i] : '0;
    return (i >= 0 && i < got_q.size()) ? got_q[i] : '0;
  endfunction

  task automatic launch(input logic [7:0] nx, input logic [6:0] ny, input logic rd);
    @(posedge clk); #1;
    alien_x = nx; alien_y = ny; redraw = rd;
    build_expected(nx, ny);
    @(negedge clk);
  endtask

  task automatic idle_watch(input string name, input int cycles);
    int act = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (plot || busy || done) act++;
    end
    checks++;
    if (act !== 0) begin
      errors++; $display("FAIL %s active cycles got %0d want 0", name, act);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; redraw = 1'b0; alien_x = 8'd98; alien_y = 7'd15;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({plot, busy, done} !== 3'b000 || vga_x !== 8'd0 || vga_y !== 7'd0 || colour !== 3'd0) begin
      errors++;
      $display("FAIL reset_state got plot%b busy%b done%b x%0d y%0d c%0d want all 0",
               plot, busy, done, vga_x, vga_y, colour);
    end
  endtask

  task automatic test_first_render();
    int d;
    @(posedge clk); #1;
    reset = 1'b0;
    m_valid = 1'b0;
    build_expected(8'd98, 7'd15);
    @(negedge clk);
    capture(200);
    checks++; d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL first_writes idx %0d got %h (n=%0d) want %h (n=%0d)",
               d, ev_at(0, d), got_q.size(), ev_at(1, d), exp_q.size());
    end
    checks++;
    if (got_q.size() != 22 || got_q[0].x != 8'd100 || got_q[0].y != 7'd15 ||
        got_q[21].x != 8'd105 || got_q[21].y != 7'd18) begin
      errors++; $display("FAIL first_span got n=%0d want n=22 from (100,15) to (105,18)", got_q.size());
    end
    checks++;
    if (done_k !== 33) begin
      errors++; $display("FAIL first_done got cycle %0d want 33", done_k);
    end
    checks++;
    if (busy_cnt !== 32 || stray !== 0) begin
      errors++; $display("FAIL first_busy got busy %0d stray %0d want 32 0", busy_cnt, stray);
    end
    idle_watch("first_idle", 12);
  endtask

  task automatic test_step();
    int d;
    launch(8'd99, 7'd15, 1'b0);
    capture(200);
    checks++; d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL step_writes idx %0d got %h (n=%0d) want %h (n=%0d)",
               d, ev_at(0, d), got_q.size(), ev_at(1, d), exp_q.size());
    end
    checks++;
    if (done_k !== 65 || busy_cnt !== 64 || stray !== 0) begin
      errors++; $display("FAIL step_timing got done %0d busy %0d stray %0d want 65 64 0", done_k, busy_cnt, stray);
    end
  endtask

  task automatic test_clip();
    int d, draws, off;
    launch(8'd156, 7'd15, 1'b0);
    capture(200);
    checks++; d = first_diff();
    if (d != -1) begin
      errors++;
      $display("FAIL clip_writes idx %0d got %h (n=%0d) want %h (n=%0d)",
               d, ev_at(0, d), got_q.size(), ev_at(1, d), exp_q.size());
    end
    draws = 0; off = 0;
    foreach (got_q[i]) begin
      if (got_q[i].c == 3'b010) draws++;
      if (got_q[i].x >= 8'd160) off++;
    end
    checks++;
    if (draws !== 11 || off !== 0) begin
      errors++; $display("FAIL clip_count got draws %0d offscreen %0d want 11 0", draws, off);
    end
  endtask

  task automatic test_change_while_busy();
    int d;
    launch(8'd99, 7'd15, 1'b0);
    capture(200, 10, 8'd100, 40, 8'd101);
    checks++; d = first_diff();
    if (d != -1 || done_k !== 65) begin
      errors++;
      $display("FAIL busy_first idx %0d got %h done %0d want %h done 65", d, ev_at(0, d), done_k, ev_at(1, d));
    end
    build_expected(8'd101, 7'd15);
    @(negedge clk);
    capture(200);
    checks++; d = first_diff();
    if (d != -1 || done_k !== 65) begin
      errors++;
      $display("FAIL busy_latest idx %0d got %h done %0d want %h done 65", d, ev_at(0, d), done_k, ev_at(1, d));
    end
    idle_watch("busy_no_third", 80);
  endtask

  task automatic test_reset_mid_draw();
    int d;
    launch(8'd40, 7'd50, 1'b0);
    repeat (42) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (plot !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset_abort got plot%b busy%b done%b want 000", plot, busy, done);
    end
    reset = 1'b0;
    m_valid = 1'b0;
    build_expected(8'd40, 7'd50);
    capture(200);
    checks++; d = first_diff();
    if (d != -1 || got_q.size() != 22 || done_k !== 33) begin
      errors++;
      $display("FAIL reset_redo idx %0d n=%0d done %0d want n=22 done 33", d, got_q.size(), done_k);
    end
  endtask

  task automatic test_redraw();
    int d;
    launch(8'd40, 7'd50, 1'b1);
    capture(200);
    checks++; d = first_diff();
    if (d != -1 || done_k !== 65) begin
      errors++;
      $display("FAIL redraw_writes idx %0d got %h done %0d want %h done 65", d, ev_at(0, d), done_k, ev_at(1, d));
    end
    idle_watch("redraw_once", 40);
  endtask

  task automatic test_random();
    int d;
    logic [7:0] nx;
    logic [6:0] ny;
    logic rd;
    for (int n = 0; n < 8; n++) begin
      rd = ($urandom_range(0, 3) == 0);
      nx = rd ? m_x : 8'($urandom_range(0, 255));
      ny = rd ? m_y : 7'($urandom_range(0, 127));
      if (!rd && nx == m_x && ny == m_y) nx = nx + 8'd1;
      launch(nx, ny, rd);
      capture(200);
      checks++; d = first_diff();
      if (d != -1 || done_k !== exp_done || busy_cnt !== exp_done - 1 || stray !== 0) begin
        errors++;
        $display("FAIL random_%0d pos (%0d,%0d) idx %0d got %h done %0d want %h done %0d",
                 n, nx, ny, d, ev_at(0, d), done_k, ev_at(1, d), exp_done);
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_render();
    test_step();
    test_clip();
    test_change_while_busy();
    test_reset_mid_draw();
    test_redraw();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
